// File: rtl/mc_control_unit.sv
// mc_control_unit -- multicycle control unit for the RV32I datapath.
//
// Sequences fetch, decode, execute, memory and write-back as a Moore FSM.
// It drives every datapath write strobe and mux select. Memory accesses
// handshake on mem_ready and are bounded by a wait-cycle timeout. Retired
// instructions are counted in instret.
//
// Optional feature: define CU_ILLEGAL_TRAP_EN to trap unknown opcodes into an
// absorbing TRAP state. Without it, unknown opcodes retire as a NOP.
//
// Parameters
//   MEM_TIMEOUT  max wait cycles per memory access (0 = wait forever)
//   TO_W         wait-counter width, MEM_TIMEOUT < 2**TO_W
//   CNT_W        retired-instruction counter width
//
// Ports
//   clk, rst_                   clock (rising edge), async active-low reset
//   opcode, func3, func7        instruction fields from IR
//   CF, OF, ZF, SF              ALU flags of rs1 - rs2
//   mem_ready / mem_req         memory handshake
//   PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_write   write strobes
//   PC_s, rs2_imm_s, w_data_s, Size_s, SE_s               mux selects
//   mem_fault, illegal_insn     sticky error indications
//   instr_done, instret         retire pulse and retired count
module mc_control_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [6:0]       opcode,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             CF,
  input  logic             OF,
  input  logic             ZF,
  input  logic             SF,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             PC_Write,
  output logic             PC0_Write,
  output logic             IR_Write,
  output logic             Reg_Write,
  output logic             Mem_write,
  output logic [1:0]       PC_s,
  output logic             rs2_imm_s,
  output logic [2:0]       w_data_s,
  output logic [1:0]       Size_s,
  output logic             SE_s,
  output logic             mem_fault,
  output logic             illegal_insn,
  output logic             instr_done,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam bit            TO_EN   = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_EN ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [4:0] {
    S_RESET, S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_WB_ALU, S_WB_LUI,
    S_WB_AUIPC, S_WB_JAL, S_ADDR, S_MEM_RD, S_WB_LD, S_MEM_WR, S_WB_JALR,
    S_BR_CMP, S_BR_RES, S_FAULT, S_TRAP
  } state_t;

  state_t          state, nxt;
  logic [TO_W-1:0] wcnt;
  logic            is_ldst, known_op, in_wait, timeout, cc;

  // func7 is carried for the external ALU decoder only.
  logic unused_func7;
  assign unused_func7 = ^func7;

  assign is_ldst  = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign known_op = (opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_JALR,
                                    OP_BR, OP_LUI, OP_AUIPC, OP_JAL});
  assign in_wait  = (state inside {S_FETCH, S_MEM_RD, S_MEM_WR});
  // Fires on the MEM_TIMEOUT-th consecutive low cycle of one access.
  assign timeout  = TO_EN && (wcnt == TO_LAST) && !mem_ready;

  always_comb begin
    cc = 1'b0;
    case (func3)
      3'b000:  cc = ZF;
      3'b001:  cc = ~ZF;
      3'b100:  cc = SF ^ OF;
      3'b101:  cc = ~(SF ^ OF);
      3'b110:  cc = CF;
      3'b111:  cc = ~CF;
      default: cc = 1'b0;
    endcase
  end

  always_comb begin
    nxt = S_RESET;
    case (state)
      S_RESET:  nxt = S_FETCH;
      S_FETCH:  nxt = mem_ready ? S_DECODE : (timeout ? S_FAULT : S_FETCH);
      S_DECODE: begin
        case (opcode)
          OP_R:                      nxt = S_EX_R;
          OP_I:                      nxt = S_EX_I;
          OP_LOAD, OP_STORE, OP_JALR: nxt = S_ADDR;
          OP_BR:                     nxt = S_BR_CMP;
          OP_LUI:                    nxt = S_WB_LUI;
          OP_AUIPC:                  nxt = S_WB_AUIPC;
          OP_JAL:                    nxt = S_WB_JAL;
`ifdef CU_ILLEGAL_TRAP_EN
          default:                   nxt = S_TRAP;
`else
          default:                   nxt = S_FETCH;
`endif
        endcase
      end
      S_EX_R, S_EX_I: nxt = S_WB_ALU;
      S_ADDR: begin
        if (opcode == OP_LOAD)       nxt = S_MEM_RD;
        else if (opcode == OP_STORE) nxt = S_MEM_WR;
        else                         nxt = S_WB_JALR;
      end
      S_MEM_RD: nxt = mem_ready ? S_WB_LD : (timeout ? S_FAULT : S_MEM_RD);
      S_MEM_WR: nxt = mem_ready ? S_FETCH : (timeout ? S_FAULT : S_MEM_WR);
      S_BR_CMP: nxt = S_BR_RES;
      S_WB_ALU, S_WB_LUI, S_WB_AUIPC, S_WB_JAL, S_WB_LD, S_WB_JALR,
      S_BR_RES: nxt = S_FETCH;
      S_FAULT:  nxt = S_FAULT;
`ifdef CU_ILLEGAL_TRAP_EN
      S_TRAP:   nxt = S_TRAP;
`endif
      default:  nxt = S_RESET;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    PC_Write   = 1'b0;
    PC0_Write  = 1'b0;
    IR_Write   = 1'b0;
    Reg_Write  = 1'b0;
    Mem_write  = 1'b0;
    PC_s       = 2'd0;
    rs2_imm_s  = 1'b0;
    w_data_s   = 3'd0;
    Size_s     = 2'd0;
    SE_s       = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        PC_Write  = mem_ready;
        PC0_Write = mem_ready;
        IR_Write  = mem_ready;
      end
`ifndef CU_ILLEGAL_TRAP_EN
      S_DECODE:   instr_done = ~known_op;
`endif
      S_EX_I, S_ADDR: rs2_imm_s = 1'b1;
      S_WB_ALU:   begin Reg_Write = 1'b1; w_data_s = 3'd0; instr_done = 1'b1; end
      S_WB_LUI:   begin Reg_Write = 1'b1; w_data_s = 3'd1; instr_done = 1'b1; end
      S_WB_AUIPC: begin Reg_Write = 1'b1; w_data_s = 3'd4; instr_done = 1'b1; end
      S_WB_LD:    begin Reg_Write = 1'b1; w_data_s = 3'd2; instr_done = 1'b1; end
      S_WB_JAL: begin
        Reg_Write = 1'b1; w_data_s = 3'd3; PC_Write = 1'b1; PC_s = 2'd1;
        instr_done = 1'b1;
      end
      S_WB_JALR: begin
        Reg_Write = 1'b1; w_data_s = 3'd3; PC_Write = 1'b1; PC_s = 2'd2;
        instr_done = 1'b1;
      end
      S_MEM_RD:   mem_req = 1'b1;
      S_MEM_WR: begin
        mem_req    = 1'b1;
        Mem_write  = mem_ready;
        instr_done = mem_ready;
      end
      S_BR_RES: begin PC_Write = cc; PC_s = 2'd1; instr_done = 1'b1; end
      default: ;
    endcase
    // Access size/sign follow the load/store instruction from address
    // generation through the data phase.
    if (is_ldst && (state inside {S_ADDR, S_MEM_RD, S_MEM_WR, S_WB_LD})) begin
      Size_s = func3[1:0];
      SE_s   = func3[2];
    end
  end

  assign mem_fault = (state == S_FAULT);
`ifdef CU_ILLEGAL_TRAP_EN
  assign illegal_insn = (state == S_TRAP);
`else
  assign illegal_insn = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state   <= S_RESET;
      wcnt    <= '0;
      instret <= '0;
    end else begin
      state <= nxt;
      // Each access gets a fresh wait budget on entry to a wait state.
      if ((nxt inside {S_FETCH, S_MEM_RD, S_MEM_WR}) && (nxt != state))
        wcnt <= '0;
      else if (in_wait && !mem_ready)
        wcnt <= wcnt + 1'b1;
      if (instr_done)
        instret <= instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Testbench for mc_control_unit: directed and randomized instruction streams
// checked cycle by cycle against a per-instruction-class reference model.
module tb_mc_control_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_;
  logic [6:0]  opcode, func7;
  logic [2:0]  func3;
  logic        CF, OF, ZF, SF, mem_ready;
  logic        mem_req, PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_write;
  logic [1:0]  PC_s, Size_s;
  logic        rs2_imm_s, SE_s, mem_fault, illegal_insn, instr_done;
  logic [2:0]  w_data_s;
  logic [31:0] instret;

  mc_control_unit #(.MEM_TIMEOUT(TO), .TO_W(8), .CNT_W(32)) dut (
    .clk(clk), .rst_(rst_), .opcode(opcode), .func3(func3), .func7(func7),
    .CF(CF), .OF(OF), .ZF(ZF), .SF(SF), .mem_ready(mem_ready),
    .mem_req(mem_req), .PC_Write(PC_Write), .PC0_Write(PC0_Write),
    .IR_Write(IR_Write), .Reg_Write(Reg_Write), .Mem_write(Mem_write),
    .PC_s(PC_s), .rs2_imm_s(rs2_imm_s), .w_data_s(w_data_s),
    .Size_s(Size_s), .SE_s(SE_s), .mem_fault(mem_fault),
    .illegal_insn(illegal_insn), .instr_done(instr_done), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, pc_w, pc0_w, ir_w, reg_w, mem_w;
    logic [1:0] pc_s;
    logic       rs2;
    logic [2:0] wd;
    logic [1:0] size;
    logic       se, done, flt, ill;
  } exp_t;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011,
    OP_L = 7'b0000011, OP_S = 7'b0100011, OP_JR = 7'b1100111,
    OP_B = 7'b1100011, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111,
    OP_JAL = 7'b1101111;

  exp_t  eq[$];
  logic  rq[$];
  int    passed = 0, total = 0, failed = 0, cyc = 0;
  int    cnt = 0;
  string cur = "init";

  function automatic exp_t obs();
    exp_t o;
    o.mem_req = mem_req;   o.pc_w = PC_Write;   o.pc0_w = PC0_Write;
    o.ir_w = IR_Write;     o.reg_w = Reg_Write; o.mem_w = Mem_write;
    o.pc_s = PC_s;         o.rs2 = rs2_imm_s;   o.wd = w_data_s;
    o.size = Size_s;       o.se = SE_s;         o.done = instr_done;
    o.flt = mem_fault;     o.ill = illegal_insn;
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    assert (got === want) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic push(input exp_t e, input logic r);
    eq.push_back(e);
    rq.push_back(r);
  endtask

  // Applies one queued cycle per clock and compares all outputs mid-cycle.
  task automatic run_queue();
    exp_t e;
    while (eq.size() > 0) begin
      @(negedge clk);
      mem_ready = rq.pop_front();
      e = eq.pop_front();
      #1;
      chk($sformatf("%s_cyc%0d", cur, cyc), obs(), e);
      cyc++;
    end
  endtask

  // Builds the expected cycle trace for one instruction from its class,
  // runs it, then checks the retired count.
  task automatic instr(input string name, input logic [6:0] op, input int fw,
                       input int mw, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3);
    exp_t e;
    logic [31:0] d;
    logic taken;
    cur = name; cyc = 0;
    opcode = op; func3 = f3; func7 = 7'($urandom);
    d = a - b;
    ZF = (d == 0); SF = d[31]; CF = (a < b);
    OF = (a[31] != b[31]) && (d[31] != a[31]);
    case (f3)
      3'd0: taken = (a == b);
      3'd1: taken = (a != b);
      3'd4: taken = ($signed(a) < $signed(b));
      3'd5: taken = ($signed(a) >= $signed(b));
      3'd6: taken = (a < b);
      3'd7: taken = (a >= b);
      default: taken = 1'b0;
    endcase
    for (int i = 0; i < fw; i++) begin
      e = '0; e.mem_req = 1; push(e, 1'b0);
    end
    e = '0; e.mem_req = 1; e.pc_w = 1; e.pc0_w = 1; e.ir_w = 1; push(e, 1'b1);
    e = '0;
    case (op)
      OP_R: begin
        push(e, 1'($urandom));
        e.rs2 = 0; push(e, 1'($urandom));
        e = '0; e.reg_w = 1; e.wd = 0; e.done = 1; push(e, 1'($urandom)); cnt++;
      end
      OP_I: begin
        push(e, 1'($urandom));
        e.rs2 = 1; push(e, 1'($urandom));
        e = '0; e.reg_w = 1; e.wd = 0; e.done = 1; push(e, 1'($urandom)); cnt++;
      end
      OP_LUI, OP_AUI, OP_JAL: begin
        push(e, 1'($urandom));
        e.reg_w = 1; e.done = 1;
        if (op == OP_LUI) e.wd = 1;
        else if (op == OP_AUI) e.wd = 4;
        else begin e.wd = 3; e.pc_w = 1; e.pc_s = 1; end
        push(e, 1'($urandom)); cnt++;
      end
      OP_JR: begin
        push(e, 1'($urandom));
        e.rs2 = 1; push(e, 1'($urandom));
        e = '0; e.reg_w = 1; e.wd = 3; e.pc_w = 1; e.pc_s = 2; e.done = 1;
        push(e, 1'($urandom)); cnt++;
      end
      OP_L, OP_S: begin
        push(e, 1'($urandom));
        e.rs2 = 1; e.size = f3[1:0]; e.se = f3[2]; push(e, 1'($urandom));
        e = '0; e.size = f3[1:0]; e.se = f3[2]; e.mem_req = 1;
        for (int i = 0; i < mw; i++) push(e, 1'b0);
        if (op == OP_S) begin e.mem_w = 1; e.done = 1; end
        push(e, 1'b1);
        if (op == OP_L) begin
          e = '0; e.size = f3[1:0]; e.se = f3[2]; e.reg_w = 1; e.wd = 2;
          e.done = 1; push(e, 1'($urandom));
        end
        cnt++;
      end
      OP_B: begin
        push(e, 1'($urandom));
        e.rs2 = 0; push(e, 1'($urandom));
        e = '0; e.pc_w = taken; e.pc_s = 1; e.done = 1; push(e, 1'($urandom));
        cnt++;
      end
      default: begin
`ifdef CU_ILLEGAL_TRAP_EN
        push(e, 1'($urandom));
        e.ill = 1;
        for (int i = 0; i < 3; i++) push(e, 1'($urandom));
`else
        e.done = 1; push(e, 1'($urandom)); cnt++;
`endif
      end
    endcase
    run_queue();
    @(posedge clk); #1;
    chk({name, "_instret"}, instret, cnt);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_ = 1'b0;
    #1;
    chk({cur, "_rst_out"}, obs(), '0);
    chk({cur, "_rst_instret"}, instret, 0);
    cnt = 0;
    @(posedge clk); #2;
    rst_ = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  ops [10];
    logic [31:0] a, b;
    exp_t e;
    int k;
    ops = '{OP_R, OP_I, OP_L, OP_S, OP_JR, OP_B, OP_LUI, OP_AUI, OP_JAL, 7'b0};
    rst_ = 1'b0; opcode = '0; func3 = '0; func7 = '0;
    CF = 0; OF = 0; ZF = 0; SF = 0; mem_ready = 0;
    #1;
    chk("reset_out", obs(), '0);
    chk("reset_instret", instret, 0);
    @(posedge clk); #2;
    rst_ = 1'b1;
    push('0, 1'b1);                         // RESET state cycle

    instr("add",     OP_R,   0, 0, 32'd1, 32'd2, 3'b000);
    instr("lw_w3",   OP_L,   0, 3, 32'd0, 32'd0, 3'b010);
    instr("blt_tk",  OP_B,   0, 0, 32'hFFFF_FFFF, 32'd0, 3'b100);
    instr("blt_nt",  OP_B,   0, 0, 32'd5, 32'd3, 3'b100);
    instr("sb_w3",   OP_S,   3, 3, 32'd0, 32'd0, 3'b000);
    instr("lui",     OP_LUI, 1, 0, 32'd0, 32'd0, 3'b000);
    instr("auipc",   OP_AUI, 0, 0, 32'd0, 32'd0, 3'b000);
    instr("jal",     OP_JAL, 2, 0, 32'd0, 32'd0, 3'b000);
    instr("jalr",    OP_JR,  0, 0, 32'd0, 32'd0, 3'b000);
    instr("addi",    OP_I,   0, 0, 32'd0, 32'd0, 3'b000);
    instr("lhu",     OP_L,   1, 0, 32'd0, 32'd0, 3'b101);
    instr("bgeu_eq", OP_B,   0, 0, 32'd7, 32'd7, 3'b111);

    for (int n = 0; n < 40; n++) begin
`ifdef CU_ILLEGAL_TRAP_EN
      k = $urandom_range(0, 8);
`else
      k = $urandom_range(0, 9);
`endif
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if (k == 9 && $urandom_range(0, 1) == 1) ops[9] = 7'b1111111;
      else ops[9] = 7'b0000000;
      instr($sformatf("rnd%0d", n), ops[k], $urandom_range(0, TO - 1),
            $urandom_range(0, TO - 1), a, b, 3'($urandom));
    end

    // Reset asserted while a store waits on memory.
    cur = "sw_rst"; cyc = 0;
    opcode = OP_S; func3 = 3'b001;
    e = '0; e.mem_req = 1; e.pc_w = 1; e.pc0_w = 1; e.ir_w = 1; push(e, 1'b1);
    push('0, 1'b0);
    e = '0; e.rs2 = 1; e.size = 2'd1; push(e, 1'b0);
    e = '0; e.mem_req = 1; e.size = 2'd1; push(e, 1'b0); push(e, 1'b0);
    run_queue();
    reset_pulse();

    // Memory never answers the fetch: fault after TO low cycles, then idle.
    cur = "timeout"; cyc = 0;
    push('0, 1'b0);
    e = '0; e.mem_req = 1;
    for (int i = 0; i < TO; i++) push(e, 1'b0);
    e = '0; e.flt = 1;
    for (int i = 0; i < 4; i++) push(e, 1'($urandom));
    run_queue();
    chk("timeout_instret", instret, 0);

`ifdef CU_ILLEGAL_TRAP_EN
    reset_pulse();
    push('0, 1'b1);
    instr("trap", 7'b0000000, 0, 0, 32'd0, 32'd0, 3'b000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
